// File: rtl/mcu_bus_pkg.sv
// Shared types and default address map for the MCU data-space bus decoder.
// Slave 0 is the ack-handshaked register arbiter window; the rest are zero-wait windows.
package mcu_bus_pkg;

    localparam int MCU_ADDR_W  = 16;
    localparam int MCU_DATA_W  = 8;
    localparam int DEF_NUM_SLV = 4;
    localparam int DEF_TIMEOUT = 15;

    // Slice i belongs to slave i, so the listing reads from slave 3 down to slave 0.
    localparam logic [DEF_NUM_SLV*MCU_ADDR_W-1:0] DEF_SLV_BASE =
        {16'h3000, 16'h2000, 16'h0000, 16'hFE00};
    localparam logic [DEF_NUM_SLV*MCU_ADDR_W-1:0] DEF_SLV_MASK =
        {16'hF000, 16'hF000, 16'hF000, 16'hFE00};
    localparam logic [DEF_NUM_SLV-1:0] DEF_SLV_ACKED = 4'b0001;

    // Every bit of the read data is forced to this value on a read timeout.
    localparam logic ERR_RDATA_BIT = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        ACKW   = 2'd2,
        DONE   = 2'd3
    } bus_state_e;

    function automatic int sel_width(input int num_slv);
        return (num_slv > 1) ? $clog2(num_slv) : 1;
    endfunction

endpackage

// File: rtl/mcu_addr_match.sv
// Per-slave base/mask compare followed by a priority encoder.
// When windows overlap, the lowest slave index wins.
module mcu_addr_match
    import mcu_bus_pkg::*;
#(
    parameter int                          NUM_SLV  = DEF_NUM_SLV,
    parameter int                          ADDR_W   = MCU_ADDR_W,
    parameter int                          SEL_W    = sel_width(DEF_NUM_SLV),
    parameter logic [NUM_SLV*ADDR_W-1:0]   SLV_BASE = DEF_SLV_BASE,
    parameter logic [NUM_SLV*ADDR_W-1:0]   SLV_MASK = DEF_SLV_MASK
)(
    input  logic [ADDR_W-1:0] i_addr,
    output logic              o_hit,
    output logic [SEL_W-1:0]  o_sel
);

    logic [NUM_SLV-1:0] w_match;

    for (genvar g = 0; g < NUM_SLV; g++) begin : g_cmp
        assign w_match[g] =
            ((i_addr & SLV_MASK[g*ADDR_W +: ADDR_W]) == SLV_BASE[g*ADDR_W +: ADDR_W]);
    end

    // Scan from the top so the lowest matching index is written last.
    always_comb begin
        o_hit = 1'b0;
        o_sel = '0;
        for (int i = NUM_SLV - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                o_hit = 1'b1;
                o_sel = SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/mcu_bus_dec.sv
// MCU data-space decoder: routes each access to one slave window, stalls the core
// via mem_wait, times out unanswered acked accesses and flags misses/timeouts.
//
//   state  | meaning
//   IDLE   | waiting for memwr/memrd; latches address, data, direction and hit
//   STROBE | one-cycle slave strobe; zero-wait slaves and immediate acks finish here
//   ACKW   | waiting for the selected slave's ack, timer running
//   DONE   | mem_wait released, mem_err pulses if the access failed
module mcu_bus_dec
    import mcu_bus_pkg::*;
#(
    parameter int                          NUM_SLV   = DEF_NUM_SLV,
    parameter int                          ADDR_W    = MCU_ADDR_W,
    parameter int                          DATA_W    = MCU_DATA_W,
    parameter logic [NUM_SLV*ADDR_W-1:0]   SLV_BASE  = DEF_SLV_BASE,
    parameter logic [NUM_SLV*ADDR_W-1:0]   SLV_MASK  = DEF_SLV_MASK,
    parameter logic [NUM_SLV-1:0]          SLV_ACKED = DEF_SLV_ACKED,
    parameter int                          TIMEOUT   = DEF_TIMEOUT
)(
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [ADDR_W-1:0]           i_memaddr,
    input  logic                        i_memwr,
    input  logic                        i_memrd,
    input  logic [DATA_W-1:0]           i_memdata_r,
    output logic [DATA_W-1:0]           o_memdata_w,
    output logic                        o_mem_wait,
    output logic                        o_mem_err,
    output logic [ADDR_W-1:0]           o_err_addr,
    output logic [ADDR_W-1:0]           o_slv_addr,
    output logic [DATA_W-1:0]           o_slv_wdata,
    output logic [NUM_SLV-1:0]          o_slv_write,
    output logic [NUM_SLV-1:0]          o_slv_read,
    input  logic [NUM_SLV*DATA_W-1:0]   i_slv_rdata,
    input  logic [NUM_SLV-1:0]          i_slv_ack
);

    localparam int                SEL_W   = sel_width(NUM_SLV);
    localparam int                TMR_W   = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0]  TMR_END = TMR_W'(TIMEOUT);

    bus_state_e           r_state;
    bus_state_e           w_state_nxt;

    logic [SEL_W-1:0]     r_sel;
    logic                 r_is_wr;
    logic                 r_err;
    logic [TMR_W-1:0]     r_tmr;
    logic [ADDR_W-1:0]    r_slv_addr;
    logic [DATA_W-1:0]    r_slv_wdata;
    logic [NUM_SLV-1:0]   r_slv_write;
    logic [NUM_SLV-1:0]   r_slv_read;
    logic [DATA_W-1:0]    r_memdata_w;
    logic [ADDR_W-1:0]    r_err_addr;

    logic                 w_req;
    logic                 w_hit;
    logic [SEL_W-1:0]     w_hit_sel;
    logic [NUM_SLV-1:0]   w_onehot;
    logic                 w_sel_ack;
    logic                 w_sel_acked;
    logic [DATA_W-1:0]    w_sel_rdata;
    logic [TMR_W-1:0]     w_tmr_nxt;

    logic                 w_mem_wait;
    logic                 w_mem_err;
    logic                 w_latch;
    logic                 w_capture;
    logic                 w_fill;
    logic                 w_tmr_clr;
    logic                 w_tmr_inc;
    logic                 w_err_set;

    assign w_req    = i_memwr | i_memrd;
    assign w_onehot = NUM_SLV'(1) << w_hit_sel;

    mcu_addr_match #(
        .NUM_SLV  (NUM_SLV),
        .ADDR_W   (ADDR_W),
        .SEL_W    (SEL_W),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_match (
        .i_addr (i_memaddr),
        .o_hit  (w_hit),
        .o_sel  (w_hit_sel)
    );

    // Only the latched slave's ack and read data are visible to the FSM.
    always_comb begin
        w_sel_ack   = 1'b0;
        w_sel_acked = 1'b0;
        w_sel_rdata = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (r_sel == SEL_W'(i)) begin
                w_sel_ack   = i_slv_ack[i];
                w_sel_acked = SLV_ACKED[i];
                w_sel_rdata = i_slv_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Counts ACKW cycles including the current one; holds at TIMEOUT instead of wrapping.
    assign w_tmr_nxt = (r_tmr == TMR_END) ? r_tmr : r_tmr + 1'b1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mem_wait  = 1'b0;
        w_mem_err   = 1'b0;
        w_latch     = 1'b0;
        w_capture   = 1'b0;
        w_fill      = 1'b0;
        w_tmr_clr   = 1'b0;
        w_tmr_inc   = 1'b0;
        w_err_set   = 1'b0;

        case (r_state)
            IDLE: begin
                w_mem_wait = w_req;
                if (w_req) begin
                    w_latch = 1'b1;
                    if (w_hit) begin
                        w_state_nxt = STROBE;
                    end else begin
                        w_err_set   = 1'b1;
                        w_state_nxt = DONE;
                    end
                end
            end

            STROBE: begin
                w_mem_wait = 1'b1;
                if (!w_sel_acked || w_sel_ack) begin
                    w_capture   = !r_is_wr;
                    w_state_nxt = DONE;
                end else begin
                    w_tmr_clr   = 1'b1;
                    w_state_nxt = ACKW;
                end
            end

            ACKW: begin
                w_mem_wait = 1'b1;
                w_tmr_inc  = 1'b1;
                // An ack in the timeout cycle still completes the access cleanly.
                if (w_sel_ack) begin
                    w_capture   = !r_is_wr;
                    w_state_nxt = DONE;
                end else if (w_tmr_nxt == TMR_END) begin
                    w_fill      = !r_is_wr;
                    w_err_set   = 1'b1;
                    w_state_nxt = DONE;
                end
            end

            DONE: begin
                w_mem_err   = r_err;
                w_state_nxt = IDLE;
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sel       <= '0;
            r_is_wr     <= 1'b0;
            r_err       <= 1'b0;
            r_tmr       <= '0;
            r_slv_addr  <= '0;
            r_slv_wdata <= '0;
            r_slv_write <= '0;
            r_slv_read  <= '0;
            r_memdata_w <= '0;
            r_err_addr  <= '0;
        end else begin
            // Strobes are loaded only on the IDLE->STROBE edge, so they last one cycle.
            r_slv_write <= '0;
            r_slv_read  <= '0;
            // Every entry into DONE passes through a cycle that decides w_err_set.
            r_err       <= w_err_set;

            if (w_latch) begin
                r_slv_addr  <= i_memaddr;
                r_slv_wdata <= i_memdata_r;
                r_is_wr     <= i_memwr;
                r_sel       <= w_hit_sel;
                if (w_hit) begin
                    if (i_memwr) begin
                        r_slv_write <= w_onehot;
                    end else begin
                        r_slv_read  <= w_onehot;
                    end
                end
            end

            if (w_err_set) begin
                r_err_addr <= (r_state == IDLE) ? i_memaddr : r_slv_addr;
            end

            if (w_tmr_clr) begin
                r_tmr <= '0;
            end else if (w_tmr_inc) begin
                r_tmr <= w_tmr_nxt;
            end

            if (w_capture) begin
                r_memdata_w <= w_sel_rdata;
            end else if (w_fill) begin
                r_memdata_w <= {DATA_W{ERR_RDATA_BIT}};
            end
        end
    end

    assign o_memdata_w = r_memdata_w;
    assign o_mem_wait  = w_mem_wait;
    assign o_mem_err   = w_mem_err;
    assign o_err_addr  = r_err_addr;
    assign o_slv_addr  = r_slv_addr;
    assign o_slv_wdata = r_slv_wdata;
    assign o_slv_write = r_slv_write;
    assign o_slv_read  = r_slv_read;

endmodule

// File: tb/tb_mcu_bus_dec.sv
// Scoreboard bench for mcu_bus_dec: each access pushes its expected outcome and the
// monitor pops and compares it in the cycle mem_wait drops while the request is held.
module tb_mcu_bus_dec;

    localparam int TMO = 15;
    localparam logic [15:0] T_BASE [4] = '{16'hFE00, 16'h0000, 16'h2000, 16'h3000};
    localparam logic [15:0] T_MASK [4] = '{16'hFE00, 16'hF000, 16'hF000, 16'hF000};
    localparam logic [3:0]  T_ACKED    = 4'b0001;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] memaddr;
    logic        memwr;
    logic        memrd;
    logic [7:0]  memdata_r;
    logic [7:0]  memdata_w;
    logic        mem_wait;
    logic        mem_err;
    logic [15:0] err_addr;
    logic [15:0] slv_addr;
    logic [7:0]  slv_wdata;
    logic [3:0]  slv_write;
    logic [3:0]  slv_read;
    logic [31:0] slv_rdata;
    logic [3:0]  slv_ack;

    always #5 clk = ~clk;

    mcu_bus_dec dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_memaddr   (memaddr),
        .i_memwr     (memwr),
        .i_memrd     (memrd),
        .i_memdata_r (memdata_r),
        .o_memdata_w (memdata_w),
        .o_mem_wait  (mem_wait),
        .o_mem_err   (mem_err),
        .o_err_addr  (err_addr),
        .o_slv_addr  (slv_addr),
        .o_slv_wdata (slv_wdata),
        .o_slv_write (slv_write),
        .o_slv_read  (slv_read),
        .i_slv_rdata (slv_rdata),
        .i_slv_ack   (slv_ack)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        string       tag;
        int          waits;
        logic [7:0]  rdata;
        logic        err;
        logic [15:0] eaddr;
        logic [7:0]  strb;
        int          strbn;
        logic [15:0] saddr;
        logic [7:0]  swdata;
    } exp_t;

    exp_t sb[$];

    // Reference state carried between accesses
    logic [7:0]  m_rdata = 8'h00;
    logic [15:0] m_eaddr = 16'h0000;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor
    int          wait_cnt = 0;
    int          strb_cnt = 0;
    logic [7:0]  strb_seen = 8'h00;
    logic [15:0] s_addr = 16'h0;
    logic [7:0]  s_wdata = 8'h0;
    int          done_cnt = 0;
    int          done_cyc = 0;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                wait_cnt = 0; strb_cnt = 0; strb_seen = 8'h00;
            end else if (memrd || memwr) begin
                if (mem_wait) begin
                    wait_cnt++;
                    if (|{slv_write, slv_read}) begin
                        strb_cnt++;
                        strb_seen = {slv_write, slv_read};
                        s_addr    = slv_addr;
                        s_wdata   = slv_wdata;
                    end
                end else begin
                    check("sb_depth", sb.size(), 1);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        check({e.tag, "_waits"}, wait_cnt, e.waits);
                        check({e.tag, "_rdata"}, memdata_w, e.rdata);
                        check({e.tag, "_err"}, mem_err, e.err);
                        check({e.tag, "_eaddr"}, err_addr, e.eaddr);
                        check({e.tag, "_strb_n"}, strb_cnt, e.strbn);
                        check({e.tag, "_strb"}, strb_seen, e.strb);
                        if (e.strbn != 0) begin
                            check({e.tag, "_saddr"}, s_addr, e.saddr);
                            check({e.tag, "_swdata"}, s_wdata, e.swdata);
                        end
                    end
                    done_cnt++;
                    done_cyc  = cyc;
                    wait_cnt  = 0; strb_cnt = 0; strb_seen = 8'h00;
                end
            end
        end
    end

    // Slave responder: ack the strobed slave ack_dly cycles after its strobe
    int         ack_dly = -1;
    logic [3:0] stray   = 4'b0000;
    int         rcnt    = -1;
    int         rsel    = 0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            slv_ack = stray;
            if (|{slv_write, slv_read}) begin
                rcnt = 0;
                for (int i = 0; i < 4; i++) if (slv_write[i] || slv_read[i]) rsel = i;
            end else if (rcnt >= 0) begin
                rcnt++;
            end
            if (rcnt >= 0 && rcnt == ack_dly) begin
                slv_ack[rsel] = 1'b1;
                rcnt = -1;
            end
        end
    end

    // Called just after a rising edge with the DUT in IDLE; returns likewise.
    task automatic access(input string tag, input bit wr, input bit rd,
                          input logic [15:0] a, input logic [7:0] wd, input int dly,
                          input logic [31:0] rdata);
        exp_t e;
        bit   hit = 0;
        int   sel = 0;
        int   start;
        for (int i = 3; i >= 0; i--) begin
            if ((a & T_MASK[i]) == T_BASE[i]) begin
                hit = 1; sel = i;
            end
        end
        e.tag = tag; e.saddr = a; e.swdata = wd;
        if (!hit) begin
            e.waits = 1; e.strb = 8'h00; e.strbn = 0;
            m_eaddr = a; e.err = 1'b1;
        end else begin
            e.strb  = wr ? {4'(1 << sel), 4'h0} : {4'h0, 4'(1 << sel)};
            e.strbn = 1;
            if (!T_ACKED[sel] || (dly >= 0 && dly <= TMO)) begin
                e.waits = T_ACKED[sel] ? 2 + dly : 2;
                e.err   = 1'b0;
                if (!wr) m_rdata = rdata[sel*8 +: 8];
            end else begin
                e.waits = 2 + TMO;
                e.err   = 1'b1;
                m_eaddr = a;
                if (!wr) m_rdata = 8'hFF;
            end
        end
        e.rdata = m_rdata;
        e.eaddr = m_eaddr;
        sb.push_back(e);

        slv_rdata = rdata;
        ack_dly   = dly;
        memaddr   = a;
        memdata_r = wd;
        memwr     = wr;
        memrd     = rd;
        start     = done_cnt;
        for (int c = 0; c < 64 && done_cnt == start; c++) begin
            @(negedge clk);
            #1;
        end
        check({tag, "_done"}, done_cnt - start, 1);
        @(posedge clk);
        #1;
        memwr = 1'b0;
        memrd = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        logic [15:0] ra;
        logic [15:0] addrs [6];
        rst = 1'b1; memaddr = '0; memwr = 1'b0; memrd = 1'b0; memdata_r = '0;
        slv_rdata = '0; slv_ack = '0;
        addrs[0] = 16'hFE04; addrs[1] = 16'h0456; addrs[2] = 16'h2FF0;
        addrs[3] = 16'h3001; addrs[4] = 16'hA000; addrs[5] = 16'hFFFF;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_memdata_w", memdata_w, 8'h00);
        check("rst_slv_addr", slv_addr, 16'h0000);
        check("rst_slv_wdata", slv_wdata, 8'h00);
        check("rst_err_addr", err_addr, 16'h0000);
        check("rst_strobes", {slv_write, slv_read}, 8'h00);
        check("rst_mem_err", mem_err, 1'b0);
        check("rst_mem_wait", mem_wait, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        access("rd_zw", 0, 1, 16'h0123, 8'h00, -1, 32'h11225A33);
        access("wr_ack3", 1, 0, 16'hFE10, 8'hC3, 3, 32'h44556677);
        access("rd_tmo", 0, 1, 16'hFE20, 8'h00, -1, 32'h01020304);
        access("rd_miss", 0, 1, 16'h8000, 8'h00, -1, 32'hAABBCCDD);
        access("rd_ack_at_tmo", 0, 1, 16'hFE40, 8'h00, TMO, 32'h9988773C);
        access("rd_ack0", 0, 1, 16'hFE01, 8'h00, 0, 32'h12345681);
        access("rd_late_ack", 0, 1, 16'hFE02, 8'h00, TMO + 1, 32'h12345699);
        access("wr_rd_both", 1, 1, 16'h2345, 8'h7E, -1, 32'hDEADBEEF);
        access("wr_s3", 1, 0, 16'h3ABC, 8'h11, -1, 32'hCAFEF00D);
        access("rd_s3", 0, 1, 16'h3ABC, 8'h00, -1, 32'hCAFEF00D);
        idle(3);

        stray = 4'b0100;
        idle(1);
        access("stray_rd", 0, 1, 16'hFE50, 8'h00, 2, 32'h00E1E2E3);
        access("stray_wr_tmo", 1, 0, 16'hFE60, 8'h99, -1, 32'h0);
        stray = 4'b0000;
        idle(2);

        access("b2b_0", 0, 1, 16'h0001, 8'h00, -1, 32'h00000A0B);
        t0 = done_cyc;
        access("b2b_1", 0, 1, 16'h2002, 8'h00, -1, 32'h0C000D0E);
        check("b2b_gap1", done_cyc - t0, 3);
        t0 = done_cyc;
        access("b2b_2", 0, 1, 16'h3003, 8'h00, -1, 32'h5F000000);
        check("b2b_gap2", done_cyc - t0, 3);
        idle(2);

        // Reset while the acked slave is being waited on
        ack_dly = -1;
        memaddr = 16'hFE30;
        memrd   = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rst   = 1'b1;
        memrd = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rstmid_mem_wait", mem_wait, 1'b0);
        check("rstmid_mem_err", mem_err, 1'b0);
        check("rstmid_strobes", {slv_write, slv_read}, 8'h00);
        check("rstmid_memdata_w", memdata_w, 8'h00);
        check("rstmid_err_addr", err_addr, 16'h0000);
        m_rdata = 8'h00;
        m_eaddr = 16'h0000;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rstmid_idle_wait", mem_wait, 1'b0);
        check("rstmid_idle_err", mem_err, 1'b0);
        @(posedge clk);
        #1;
        access("rstmid_reissue", 0, 1, 16'hFE30, 8'h00, 3, 32'h000000A7);

        for (int n = 0; n < 16; n++) begin
            ra = addrs[$urandom_range(0, 5)];
            access("rand", 1'($urandom_range(0, 1)), 1'b1, ra, 8'($urandom),
                   $urandom_range(0, 4), $urandom);
            if ($urandom_range(0, 2) == 0) idle(1);
        end

        idle(3);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
